// File: rtl/xbox_xmem_pkg.sv
`default_nettype none
// =============================================================================
// xbox_xmem_pkg : shared line/address layout and SOC arbiter state encoding
// Rev 1.0
// =============================================================================
package xbox_xmem_pkg;

  localparam int LINE_BYTES     = 32;
  localparam int WORDS_PER_LINE = 8;
  localparam int WORD_LSB       = 2;
  localparam int LINE_LSB       = 5;
  localparam int BANK_W         = 3;
  localparam int SOC_ADDR_W     = 19;

  typedef logic [WORDS_PER_LINE-1:0][31:0] line_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    RDATA  = 2'd2
  } soc_st_e;

endpackage : xbox_xmem_pkg
`default_nettype wire

// File: rtl/xbox_xmem_bank.sv
`default_nettype none
// =============================================================================
// xbox_xmem_bank : one bank of 256-bit lines, byte-enabled write, registered read
// Rev 1.0
// =============================================================================
module xbox_xmem_bank
  import xbox_xmem_pkg::*;
#(
  parameter int LOG2_LINES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LOG2_LINES-1:0] addr,
  input  logic                  wr,
  input  logic [LINE_BYTES-1:0] be,
  input  line_t                 wdata,
  input  logic                  rd,
  output line_t                 rd_line,
  output line_t                 rdata
);

  localparam int LINES = 1 << LOG2_LINES;

  logic [LINE_BYTES*8-1:0] mem_q [LINES];
  logic [LINE_BYTES*8-1:0] mem_d [LINES];
  line_t                   rdata_q;
  line_t                   rdata_d;
  logic [LINE_BYTES*8-1:0] wdata_flat;

  assign wdata_flat = wdata;
  assign rd_line    = mem_q[addr];
  assign rdata      = rdata_q;

  // Read samples the pre-write contents, so rd+wr on one line returns old data.
  always_comb begin
    mem_d   = mem_q;
    rdata_d = rdata_q;
    if (rd) begin
      rdata_d = mem_q[addr];
    end
    if (wr) begin
      for (int i = 0; i < LINE_BYTES; i++) begin
        if (be[i]) begin
          mem_d[addr][i*8 +: 8] = wdata_flat[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

endmodule : xbox_xmem_bank
`default_nettype wire

// File: rtl/xbox_xmem_resp.sv
`default_nettype none
// =============================================================================
// xbox_xmem_resp : banked line memory shared by accelerator lanes and a SOC word port
// Rev 1.0
// =============================================================================
module xbox_xmem_resp
  import xbox_xmem_pkg::*;
#(
  parameter int NUM_MEMS           = 1,
  parameter int LOG2_LINES_PER_MEM = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0]  xlr_mem_addr,
  input  logic [NUM_MEMS-1:0][7:0][31:0]               xlr_mem_wdata,
  input  logic [NUM_MEMS-1:0][31:0]                    xlr_mem_be,
  input  logic [NUM_MEMS-1:0]                          xlr_mem_rd,
  input  logic [NUM_MEMS-1:0]                          xlr_mem_wr,
  output logic [NUM_MEMS-1:0][7:0][31:0]               xlr_mem_rdata,
  input  logic                                         soc_req,
  input  logic                                         soc_we,
  input  logic [18:0]                                  soc_addr,
  input  logic [31:0]                                  soc_wdata,
  input  logic [3:0]                                   soc_be,
  output logic                                         soc_gnt,
  output logic                                         soc_rvalid,
  output logic [31:0]                                  soc_rdata,
  output logic                                         soc_err,
  output logic                                         trig_soc_xmem_wr,
  output logic [18:0]                                  trig_soc_xmem_wr_addr
);

  soc_st_e                         st_q, st_d;
  logic [31:0]                     soc_rdata_q, soc_rdata_d;

  logic [2:0]                      soc_word_idx;
  logic [LOG2_LINES_PER_MEM-1:0]   soc_line;
  logic [BANK_W-1:0]               soc_bank;
  logic                            soc_bank_bad;
  logic                            soc_bank_busy;
  logic [31:0]                     soc_word;
  logic [LINE_BYTES-1:0]           soc_be_lane;
  line_t                           bank_rd_line [NUM_MEMS];

  assign soc_word_idx = soc_addr[WORD_LSB +: 3];
  assign soc_line     = soc_addr[LINE_LSB +: LOG2_LINES_PER_MEM];
  assign soc_bank     = soc_addr[LINE_LSB + LOG2_LINES_PER_MEM +: BANK_W];
  assign soc_bank_bad = int'(soc_bank) >= NUM_MEMS;
  assign soc_be_lane  = {28'b0, soc_be} << {soc_word_idx, 2'b00};

  always_comb begin
    soc_bank_busy = 1'b0;
    soc_word      = '0;
    for (int i = 0; i < NUM_MEMS; i++) begin
      if (soc_bank == BANK_W'(i)) begin
        soc_bank_busy = xlr_mem_rd[i] | xlr_mem_wr[i];
        soc_word      = bank_rd_line[i][soc_word_idx];
      end
    end
  end

  // Accelerator owns a bank whenever it strobes it; the SOC waits in DECODE.
  always_comb begin
    st_d        = st_q;
    soc_rdata_d = soc_rdata_q;
    soc_gnt     = 1'b0;
    soc_err     = 1'b0;
    case (st_q)
      IDLE: begin
        if (soc_req) st_d = DECODE;
      end
      DECODE: begin
        if (!soc_req) begin
          st_d = IDLE;
        end else if (soc_bank_bad) begin
          soc_gnt = 1'b1;
          soc_err = 1'b1;
          if (!soc_we) begin
            soc_rdata_d = '0;
            st_d        = RDATA;
          end else begin
            st_d = IDLE;
          end
        end else if (!soc_bank_busy) begin
          soc_gnt = 1'b1;
          if (!soc_we) begin
            soc_rdata_d = soc_word;
            st_d        = RDATA;
          end else begin
            st_d = IDLE;
          end
        end
      end
      RDATA:   st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= IDLE;
      soc_rdata_q <= '0;
    end else begin
      st_q        <= st_d;
      soc_rdata_q <= soc_rdata_d;
    end
  end

  assign soc_rvalid            = (st_q == RDATA);
  assign soc_rdata             = soc_rdata_q;
  assign trig_soc_xmem_wr      = soc_gnt & soc_we & ~soc_err;
  assign trig_soc_xmem_wr_addr = trig_soc_xmem_wr ? soc_addr : '0;

  for (genvar b = 0; b < NUM_MEMS; b++) begin : g_bank
    logic                          soc_hit;
    logic [LOG2_LINES_PER_MEM-1:0] bank_addr;
    logic                          bank_wr;
    logic [LINE_BYTES-1:0]         bank_be;
    line_t                         bank_wdata;
    line_t                         bank_rdata;

    assign soc_hit    = (st_q == DECODE) && soc_req && (soc_bank == BANK_W'(b))
                        && !(xlr_mem_rd[b] | xlr_mem_wr[b]);
    assign bank_addr  = soc_hit ? soc_line : xlr_mem_addr[b];
    assign bank_wr    = soc_hit ? soc_we : xlr_mem_wr[b];
    assign bank_be    = soc_hit ? soc_be_lane : xlr_mem_be[b];
    assign bank_wdata = soc_hit ? {WORDS_PER_LINE{soc_wdata}} : xlr_mem_wdata[b];

    xbox_xmem_bank #(
      .LOG2_LINES (LOG2_LINES_PER_MEM)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .addr    (bank_addr),
      .wr      (bank_wr),
      .be      (bank_be),
      .wdata   (bank_wdata),
      .rd      (xlr_mem_rd[b]),
      .rd_line (bank_rd_line[b]),
      .rdata   (bank_rdata)
    );

    assign xlr_mem_rdata[b] = bank_rdata;
  end

endmodule : xbox_xmem_resp
`default_nettype wire
